// File: rtl/ram_memory_loadable.sv
// rtl/ram_memory_loadable.sv - word RAM with byte-strobed random access and a sequential load path
// Optional macro RAM_MEMORY_BYTE_STROBE_EN: honour i_byte_enable on random writes (else full-word).
module ram_memory_loadable #(
  parameter int NB_DATA   = 32,
  parameter int NB_BYTE   = 8,
  parameter int RAM_DEPTH = 256,
  localparam int NB_ADDRESS = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int NB_LANES   = NB_DATA / NB_BYTE
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_ADDRESS-1:0] i_address,
  input  logic [NB_DATA-1:0]    i_write_data,
  input  logic                  i_write_enable,
  input  logic [NB_LANES-1:0]   i_byte_enable,
  input  logic                  i_read_enable,
  output logic [NB_DATA-1:0]    o_data,
  input  logic                  i_load_enable,
  input  logic [NB_DATA-1:0]    i_load_data,
  input  logic                  i_load_next,
  output logic [NB_ADDRESS:0]   o_load_count,
  output logic                  o_load_full,
  output logic                  o_load_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOADING,
    ST_FULL
  } load_state_e;

  localparam logic [NB_ADDRESS:0] DEPTH_CNT = (NB_ADDRESS + 1)'(RAM_DEPTH);
  localparam logic [NB_ADDRESS:0] CNT_ONE   = (NB_ADDRESS + 1)'(1);

  logic [NB_DATA-1:0] mem [RAM_DEPTH];

  load_state_e          state_q, state_d;
  logic [NB_ADDRESS:0]  count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [NB_DATA-1:0]   data_q, data_d;

  logic                  load_we;
  logic [NB_ADDRESS-1:0] load_addr;
  logic                  addr_in_range;
  logic                  wr_en;
  logic [NB_ADDRESS-1:0] wr_addr;
  logic [NB_DATA-1:0]    wr_data;
  logic [NB_LANES-1:0]   wr_mask;

  assign addr_in_range = ({1'b0, i_address} < DEPTH_CNT);

  // The load pointer is the fill count itself: it only ever increments within a session.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    load_we    = 1'b0;
    load_addr  = count_q[NB_ADDRESS-1:0];
    case (state_q)
      ST_IDLE: begin
        if (i_load_enable) begin
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = ST_LOADING;
          load_addr  = '0;
          if (i_load_next) begin
            load_we = 1'b1;
            count_d = CNT_ONE;
            if (CNT_ONE == DEPTH_CNT) state_d = ST_FULL;
          end
        end
      end
      ST_LOADING: begin
        if (!i_load_enable) begin
          state_d = ST_IDLE;
        end else if (i_load_next) begin
          load_we = 1'b1;
          count_d = count_q + CNT_ONE;
          if (count_d == DEPTH_CNT) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (!i_load_enable) state_d = ST_IDLE;
        else if (i_load_next) overflow_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single write port: load path wins; random writes are dropped for the whole session.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = i_address;
    wr_data = i_write_data;
    wr_mask = '1;
    if (load_we) begin
      wr_en   = 1'b1;
      wr_addr = load_addr;
      wr_data = i_load_data;
    end else if (i_write_enable && !i_load_enable && addr_in_range) begin
      wr_en = 1'b1;
`ifdef RAM_MEMORY_BYTE_STROBE_EN
      wr_mask = i_byte_enable;
`endif
    end
  end

`ifndef RAM_MEMORY_BYTE_STROBE_EN
  logic unused_byte_enable;
  assign unused_byte_enable = ^i_byte_enable;
`endif

  always_comb begin
    data_d = data_q;
    if (i_read_enable) data_d = addr_in_range ? mem[i_address] : '0;
  end

  always_ff @(posedge i_clock) begin
    for (int k = 0; k < NB_LANES; k++) begin
      if (wr_en && wr_mask[k]) mem[wr_addr][k*NB_BYTE +: NB_BYTE] <= wr_data[k*NB_BYTE +: NB_BYTE];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
    end
  end

  assign o_data          = data_q;
  assign o_load_count    = count_q;
  assign o_load_full     = (count_q == DEPTH_CNT);
  assign o_load_overflow = overflow_q;

endmodule

// File: tb/tb_ram_memory_loadable.sv
// tb/tb_ram_memory_loadable.sv - scoreboard bench for ram_memory_loadable (RAM_DEPTH=300)
module tb_ram_memory_loadable;
  localparam int DEPTH = 300;
  localparam int NA    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [NA-1:0] address;
  logic [31:0]   write_data;
  logic          write_enable;
  logic [3:0]    byte_enable;
  logic          read_enable;
  logic [31:0]   data;
  logic          load_enable;
  logic [31:0]   load_data;
  logic          load_next;
  logic [NA:0]   load_count;
  logic          load_full;
  logic          load_overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ram_memory_loadable #(.NB_DATA(32), .NB_BYTE(8), .RAM_DEPTH(DEPTH)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_address(address),
    .i_write_data(write_data),
    .i_write_enable(write_enable),
    .i_byte_enable(byte_enable),
    .i_read_enable(read_enable),
    .o_data(data),
    .i_load_enable(load_enable),
    .i_load_data(load_data),
    .i_load_next(load_next),
    .o_load_count(load_count),
    .o_load_full(load_full),
    .o_load_overflow(load_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One clock edge; a read issued for this edge is popped and compared just after it.
  task automatic step();
    logic did_read;
    did_read = read_enable;
    @(posedge clk);
    #1;
    if (did_read) begin
      if (exp_q.size() == 0) check_eq("scoreboard_empty", 32'd1, 32'd0);
      else check_eq("read_data", data, exp_q.pop_front());
    end
  endtask

  task automatic do_read(input int addr, input logic [31:0] exp);
    address     = NA'(addr);
    read_enable = 1'b1;
    exp_q.push_back(exp);
    step();
    read_enable = 1'b0;
  endtask

  task automatic do_write(input int addr, input logic [31:0] wd, input logic [3:0] be);
    address      = NA'(addr);
    write_data   = wd;
    byte_enable  = be;
    write_enable = 1'b1;
    step();
    write_enable = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] wd);
    load_data = wd;
    load_next = 1'b1;
    step();
    load_next = 1'b0;
  endtask

  initial begin
    logic [31:0] strobe_exp;
    rst = 1'b1; address = '0; write_data = '0; write_enable = 1'b0; byte_enable = '0;
    read_enable = 1'b0; load_enable = 1'b0; load_data = '0; load_next = 1'b0;
    #12;
    check_eq("reset_data", data, 32'h0);
    check_eq("reset_count", 32'(load_count), 32'd0);
    check_eq("reset_full", 32'(load_full), 32'd0);
    check_eq("reset_overflow", 32'(load_overflow), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // First session: three words, random write to a loaded word is dropped.
    load_enable = 1'b1; step();
    load_word(32'hAABBCC55);
    load_word(32'h11223344);
    load_word(32'h89ABCDEF);
    check_eq("count_3", 32'(load_count), 32'd3);
    check_eq("not_full_3", 32'(load_full), 32'd0);
    do_write(1, 32'hDEADBEEF, 4'hF);
    do_read(0, 32'hAABBCC55);
    do_read(1, 32'h11223344);
    do_read(2, 32'h89ABCDEF);

    // Restart with load_next on the rising edge of load_enable.
    load_enable = 1'b0; step();
    check_eq("idle_count_hold", 32'(load_count), 32'd3);
    load_enable = 1'b1; load_word(32'h00AA00BB);
    check_eq("restart_count", 32'(load_count), 32'd1);
    do_read(0, 32'h00AA00BB);
    do_read(1, 32'h11223344);

    // Asynchronous reset mid-cycle and mid-load.
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_data", data, 32'h0);
    check_eq("async_rst_count", 32'(load_count), 32'd0);
    load_enable = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    do_read(0, 32'h00AA00BB);
    do_read(2, 32'h89ABCDEF);

    // Fill to depth, then overflow.
    load_enable = 1'b1; step();
    for (int i = 0; i < DEPTH; i++) begin
      load_word(32'h10000000 + i);
      if (i == DEPTH - 2) begin
        check_eq("almost_full_count", 32'(load_count), DEPTH - 1);
        check_eq("almost_full_flag", 32'(load_full), 32'd0);
      end
    end
    check_eq("full_count", 32'(load_count), DEPTH);
    check_eq("full_flag", 32'(load_full), 32'd1);
    check_eq("no_overflow_yet", 32'(load_overflow), 32'd0);
    load_word(32'hBAD00001);
    load_word(32'hBAD00002);
    check_eq("overflow_flag", 32'(load_overflow), 32'd1);
    check_eq("overflow_count", 32'(load_count), DEPTH);
    load_enable = 1'b0; step();
    check_eq("idle_full_hold", 32'(load_full), 32'd1);
    check_eq("idle_ovf_hold", 32'(load_overflow), 32'd1);
    do_read(0, 32'h10000000);
    do_read(DEPTH - 1, 32'h10000000 + DEPTH - 1);
    load_enable = 1'b1; step();
    check_eq("new_session_count", 32'(load_count), 32'd0);
    check_eq("new_session_ovf", 32'(load_overflow), 32'd0);
    check_eq("new_session_full", 32'(load_full), 32'd0);
    load_enable = 1'b0; step();

    // Byte strobes.
    do_write(5, 32'h11001100, 4'hF);
    do_write(5, 32'hFFFFFFFF, 4'b0101);
`ifdef RAM_MEMORY_BYTE_STROBE_EN
    strobe_exp = 32'h11FF11FF;
`else
    strobe_exp = 32'hFFFFFFFF;
`endif
    do_read(5, strobe_exp);

    // Read-first on a same-edge write, then read hold.
    do_write(7, 32'h0, 4'hF);
    address = NA'(7); write_data = 32'h5555AAAA; byte_enable = 4'hF;
    write_enable = 1'b1; read_enable = 1'b1; exp_q.push_back(32'h0);
    step();
    write_enable = 1'b0; read_enable = 1'b0;
    do_read(7, 32'h5555AAAA);
    address = NA'(5); step(); step();
    check_eq("read_hold", data, 32'h5555AAAA);

    // Out-of-range address.
    do_write(DEPTH, 32'h12345678, 4'hF);
    do_read(DEPTH, 32'h0);
    do_read(DEPTH - 1, 32'h10000000 + DEPTH - 1);

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
